bird_motion: RTL and testbench

BIRD_MOTION -- requirements
Module: bird_motion

---
 rtl/game_pkg.sv | 25 ++
 rtl/edge_detect.sv | 23 ++
 rtl/bird_motion.sv | 182 ++++++++++++++++++
 tb/tb_bird_motion.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: game-wide state encoding, screen geometry and default bird motion constants.
package game_pkg;

   typedef enum logic [1:0] {
      START    = 2'b00,
      GAME     = 2'b01,
      GAMEOVER = 2'b10
   } game_state_t;

   typedef enum logic [1:0] {
      HOVER  = 2'b00,
      FLY    = 2'b01,
      FALL   = 2'b10,
      LANDED = 2'b11
   } motion_state_t;

   localparam int SCREEN_H     = 600;
   localparam int BIRD_H       = 32;
   localparam int Y_FLOOR_DEF  = SCREEN_H - BIRD_H;
   localparam int Y_START_DEF  = Y_FLOOR_DEF / 2;
   localparam int GRAVITY_DEF  = 1;
   localparam int FLAP_VEL_DEF = -8;
   localparam int VEL_MAX_DEF  = 10;

endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on the rising edge of a level input.
// The pulse is combinational so an edge can be seen in the same cycle it arrives.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev_r;

   // Previous input level, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_r <= 1'b0;
      end else begin
         prev_r <= level;
      end
   end

   assign pulse = level & ~prev_r;

endmodule

// File: rtl/bird_motion.sv
// bird_motion: per-frame vertical motion of the player bird (flap, gravity, floor/ceiling).
// Optional build macro BIRD_CEILING_HIT_EN: touching the top edge counts as a hit and drops the bird.
module bird_motion
   import game_pkg::*;
#(
   parameter int Y_START  = Y_START_DEF,
   parameter int Y_FLOOR  = Y_FLOOR_DEF,
   parameter int GRAVITY  = GRAVITY_DEF,
   parameter int FLAP_VEL = FLAP_VEL_DEF,
   parameter int VEL_MAX  = VEL_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_tick,
   input  logic              mouse_left,
   input  logic [1:0]        state,
   input  logic              game_rst,
   output logic [10:0]       bird_y,
   output logic signed [7:0] bird_vel,
   output logic              bird_hit
);

   localparam logic signed [12:0] Y_FLOOR_S  = 13'(Y_FLOOR);
   localparam logic signed [12:0] GRAVITY_S  = 13'(GRAVITY);
   localparam logic signed [12:0] FLAP_VEL_S = 13'(FLAP_VEL);
   localparam logic signed [12:0] VEL_MAX_S  = 13'(VEL_MAX);
   localparam logic [10:0]        Y_START_U  = 11'(Y_START);
   localparam logic [10:0]        Y_FLOOR_U  = 11'(Y_FLOOR);

   motion_state_t      mstate_r, mstate_s;
   game_state_t        game_s;
   logic [10:0]        y_r, y_s;
   logic signed [7:0]  vel_r, vel_s;
   logic               hit_r, hit_s;
   logic               pend_r, pend_s;
   logic               flap_s, flap_eff_s, go_hover_s, clr_s;
   logic signed [12:0] y_cur_s, vel_sum_s, vel_grav_s, vel_fly_s, y_fly_s, y_fall_s;

   assign clr_s = rst | game_rst;

   edge_detect u_flap_edge (
      .clk   (clk),
      .rst   (clr_s),
      .level (mouse_left),
      .pulse (flap_s)
   );

   // Decode the game FSM state; the unused code 11 behaves as START.
   always_comb begin
      case (state)
         2'b01:   game_s = GAME;
         2'b10:   game_s = GAMEOVER;
         default: game_s = START;
      endcase
   end

   // Candidate velocity and position for this frame in 13-bit signed arithmetic.
   always_comb begin
      y_cur_s    = signed'({2'b00, y_r});
      vel_sum_s  = 13'(vel_r) + GRAVITY_S;
      vel_grav_s = (vel_sum_s > VEL_MAX_S) ? VEL_MAX_S : vel_sum_s;
      flap_eff_s = pend_r | flap_s;
      vel_fly_s  = flap_eff_s ? FLAP_VEL_S : vel_grav_s;
      y_fly_s    = y_cur_s + vel_fly_s;
      y_fall_s   = y_cur_s + vel_grav_s;
   end

   // Motion FSM next state and next register values.
   always_comb begin
      mstate_s   = mstate_r;
      y_s        = y_r;
      vel_s      = vel_r;
      hit_s      = hit_r;
      go_hover_s = 1'b0;
      pend_s     = frame_tick ? 1'b0 : (pend_r | flap_s);

      if (game_rst) begin
         pend_s     = 1'b0;
         go_hover_s = 1'b1;
      end else begin
         case (mstate_r)
            HOVER: begin
               if (game_s == GAME) begin
                  mstate_s = FLY;
               end else begin
                  go_hover_s = 1'b1;
               end
            end
            FLY: begin
               if (game_s == START) begin
                  go_hover_s = 1'b1;
               end else if (game_s != GAME) begin
                  mstate_s = FALL;
               end else if (frame_tick) begin
                  if (y_fly_s >= Y_FLOOR_S) begin
                     y_s      = Y_FLOOR_U;
                     vel_s    = 8'sd0;
                     hit_s    = 1'b1;
                     mstate_s = LANDED;
                  end else if (y_fly_s <= 13'sd0) begin
                     // Velocity is zeroed at the top edge so the bird restarts from rest.
                     y_s   = 11'd0;
                     vel_s = 8'sd0;
`ifdef BIRD_CEILING_HIT_EN
                     hit_s    = 1'b1;
                     mstate_s = FALL;
`else
                     hit_s    = hit_r;
                     mstate_s = FLY;
`endif
                  end else begin
                     y_s   = y_fly_s[10:0];
                     vel_s = vel_fly_s[7:0];
                  end
               end else begin
                  mstate_s = FLY;
               end
            end
            FALL: begin
               if (game_s == START) begin
                  go_hover_s = 1'b1;
               end else if (frame_tick) begin
                  if (y_fall_s >= Y_FLOOR_S) begin
                     y_s      = Y_FLOOR_U;
                     vel_s    = 8'sd0;
                     mstate_s = LANDED;
                  end else if (y_fall_s < 13'sd0) begin
                     y_s   = 11'd0;
                     vel_s = vel_grav_s[7:0];
                  end else begin
                     y_s   = y_fall_s[10:0];
                     vel_s = vel_grav_s[7:0];
                  end
               end else begin
                  mstate_s = FALL;
               end
            end
            LANDED: begin
               if (game_s == START) begin
                  go_hover_s = 1'b1;
               end else begin
                  mstate_s = LANDED;
               end
            end
            default: begin
               go_hover_s = 1'b1;
            end
         endcase
      end

      if (go_hover_s) begin
         mstate_s = HOVER;
         y_s      = Y_START_U;
         vel_s    = 8'sd0;
         hit_s    = 1'b0;
      end else begin
         mstate_s = mstate_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstate_r <= HOVER;
         y_r      <= Y_START_U;
         vel_r    <= 8'sd0;
         hit_r    <= 1'b0;
         pend_r   <= 1'b0;
      end else begin
         mstate_r <= mstate_s;
         y_r      <= y_s;
         vel_r    <= vel_s;
         hit_r    <= hit_s;
         pend_r   <= pend_s;
      end
   end

   assign bird_y   = y_r;
   assign bird_vel = vel_r;
   assign bird_hit = hit_r;

endmodule

// File: tb/tb_bird_motion.sv
// tb_bird_motion: scoreboard bench for bird_motion; expected values are queued by the
// stimulus and checked by a monitor one cycle after every tick/reset event.
module tb_bird_motion;

   logic              clk = 1'b0;
   logic              rst;
   logic              frame_tick;
   logic              mouse_left;
   logic [1:0]        state;
   logic              game_rst;
   logic              force_chk;
   logic [10:0]       bird_y;
   logic signed [7:0] bird_vel;
   logic              bird_hit;

   typedef struct {
      int y;
      int v;
      int h;
   } exp_t;

   exp_t sb_q[$];
   exp_t last_exp;
   bit   have_last = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   m_y, m_v, m_h, m_mode;   // mode: 0 hover, 1 fly, 2 fall, 3 landed

   bird_motion dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .mouse_left (mouse_left),
      .state      (state),
      .game_rst   (game_rst),
      .bird_y     (bird_y),
      .bird_vel   (bird_vel),
      .bird_hit   (bird_hit)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input exp_t e);
      n_tests++;
      if (int'(bird_y) != e.y || int'(bird_vel) != e.v || int'(bird_hit) != e.h) begin
         n_fail++;
         $display("FAIL %s @%0t: got y=%0d vel=%0d hit=%0d, want y=%0d vel=%0d hit=%0d",
                  name, $time, bird_y, bird_vel, bird_hit, e.y, e.v, e.h);
      end
   endtask

   // Monitor: an event edge must produce the next queued value; otherwise outputs hold.
   always @(posedge clk) begin : monitor
      bit   ev;
      exp_t e;
      ev = frame_tick | rst | game_rst | force_chk;
      @(negedge clk);
      if (ev) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty @%0t: output event with no expected entry", $time);
         end else begin
            e = sb_q.pop_front();
            check("event", e);
            last_exp  = e;
            have_last = 1'b1;
         end
      end else if (have_last) begin
         check("hold", last_exp);
      end
   end

   task automatic exp_push(input int y, input int v, input int h);
      m_y = y;
      m_v = v;
      m_h = h;
      sb_q.push_back('{y, v, h});
   endtask

   // Reference behaviour of one frame tick.
   task automatic model_tick(input bit flap);
      int vn, yn;
      vn = m_v + 1;
      if (vn > 10) vn = 10;
      case (m_mode)
         1: begin
            if (flap) vn = -8;
            yn = m_y + vn;
            if (yn >= 568) begin
               m_y = 568; m_v = 0; m_h = 1; m_mode = 3;
            end else if (yn <= 0) begin
               m_y = 0; m_v = 0;
`ifdef BIRD_CEILING_HIT_EN
               m_h = 1; m_mode = 2;
`endif
            end else begin
               m_y = yn; m_v = vn;
            end
         end
         2: begin
            yn = m_y + vn;
            if (yn >= 568) begin
               m_y = 568; m_v = 0; m_mode = 3;
            end else if (yn < 0) begin
               m_y = 0; m_v = vn;
            end else begin
               m_y = yn; m_v = vn;
            end
         end
         default: begin
         end
      endcase
      sb_q.push_back('{m_y, m_v, m_h});
   endtask

   // kind 0: plain tick; 1: click two cycles before the tick; 2: click in the tick cycle.
   task automatic drive_tick(input int kind);
      case (kind)
         1: begin
            @(negedge clk); mouse_left = 1'b1;
            @(negedge clk); mouse_left = 1'b0;
            @(negedge clk); frame_tick = 1'b1;
         end
         2: begin
            @(negedge clk); mouse_left = 1'b1; frame_tick = 1'b1;
         end
         default: begin
            @(negedge clk); frame_tick = 1'b1;
         end
      endcase
      @(negedge clk);
      frame_tick = 1'b0;
      mouse_left = 1'b0;
   endtask

   task automatic enter_fly();
      @(negedge clk); state = 2'b01;
      @(negedge clk); m_mode = 1;
   endtask

   initial begin
      rst = 1'b1; frame_tick = 1'b0; mouse_left = 1'b0;
      game_rst = 1'b0; force_chk = 1'b0; state = 2'b00;
      m_mode = 0;
      exp_push(284, 0, 0);
      @(negedge clk); rst = 1'b0;

      // Hovering in START ignores ticks and clicks.
      for (int i = 0; i < 5; i++) begin
         model_tick(1'b1);
         drive_tick(i % 3);
      end

      // First frames of flight, then flaps at vel 5.
      enter_fly();
      exp_push(285, 1, 0); drive_tick(0);
      exp_push(287, 2, 0); drive_tick(0);
      exp_push(290, 3, 0); drive_tick(0);
      exp_push(294, 4, 0); drive_tick(0);
      exp_push(299, 5, 0); drive_tick(0);
      exp_push(291, -8, 0); drive_tick(1);
      exp_push(283, -8, 0); drive_tick(2);
      exp_push(276, -7, 0); drive_tick(0);
      exp_push(270, -6, 0); drive_tick(0);

      // game_rst together with tick and click aborts motion.
      @(negedge clk);
      game_rst = 1'b1; frame_tick = 1'b1; mouse_left = 1'b1;
      exp_push(284, 0, 0); m_mode = 0;
      @(negedge clk);
      game_rst = 1'b0; frame_tick = 1'b0; mouse_left = 1'b0;
      @(negedge clk); m_mode = 1;

      // Free fall to the floor, then hold.
      for (int i = 0; i < 60 && m_mode != 3; i++) begin
         model_tick(1'b0); drive_tick(0);
      end
      for (int i = 0; i < 3; i++) begin
         model_tick(1'b1); drive_tick(2);
      end

      // Illegal state code acts as START and restores hover values.
      @(negedge clk);
      state = 2'b11; force_chk = 1'b1;
      exp_push(284, 0, 0); m_mode = 0;
      @(negedge clk); force_chk = 1'b0;
      repeat (2) @(negedge clk);
      enter_fly();

      // Flap to the top edge, keep flapping there, then fall to the floor.
      for (int i = 0; i < 50 && m_y != 0; i++) begin
         model_tick(1'b1); drive_tick(1);
      end
      for (int i = 0; i < 2; i++) begin
         model_tick(1'b1); drive_tick(2);
      end
      for (int i = 0; i < 80 && m_mode != 3; i++) begin
         model_tick(1'b0); drive_tick(0);
      end

      // Full reset with a tick in the same cycle, then pipe-collision fall.
      @(negedge clk);
      rst = 1'b1; frame_tick = 1'b1;
      exp_push(284, 0, 0); m_mode = 0;
      @(negedge clk); rst = 1'b0; frame_tick = 1'b0;
      @(negedge clk); m_mode = 1;
      for (int i = 0; i < 4; i++) begin
         model_tick(1'b0); drive_tick(0);
      end
      @(negedge clk); state = 2'b10;
      @(negedge clk); m_mode = 2;
      for (int i = 0; i < 80 && m_mode != 3; i++) begin
         model_tick(1'b1); drive_tick(2);
      end
      model_tick(1'b0); drive_tick(0);

      repeat (3) @(negedge clk);
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_left: %0d expected entries never checked, want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within 500000 time units");
      $fatal(1, "timeout");
   end

endmodule
